caravel_uart_rx: RTL and testbench

CARAVEL_UART_RX -- requirements
Module: caravel_uart_rx

---
 rtl/caravel_uart_rx.sv | 142 ++++++++++++++
 tb/tb_caravel_uart_rx.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/caravel_uart_rx.sv
// caravel_uart_rx: 8N1 UART receiver with an AXI-Stream style output register.
// The line is double-synchronized, then sampled at mid-bit by a simple
// IDLE/START/DATA/STOP state machine. A byte that is still pending when the
// next good frame completes is overwritten, and overrun_error flags the loss.
`timescale 1ns/1ps

module caravel_uart_rx #(
  parameter int CLKS_PER_BIT = 416,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rxd,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic                  overrun_error,
  output logic                  frame_error
);

  localparam int TIMER_W = $clog2(CLKS_PER_BIT) + 1;
  localparam int INDEX_W = $clog2(DATA_WIDTH) + 1;

  localparam logic [TIMER_W-1:0] HALF_LOAD  = TIMER_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TIMER_W-1:0] FULL_LOAD  = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
  localparam logic [INDEX_W-1:0] LAST_INDEX = INDEX_W'(DATA_WIDTH - 1);
  localparam logic [INDEX_W-1:0] INDEX_ONE  = INDEX_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                state;
  logic [TIMER_W-1:0]    timer;
  logic [INDEX_W-1:0]    index;
  logic [DATA_WIDTH-1:0] shift;
  logic                  rxd_meta;
  logic                  rxd_reg;

  // Two-flop synchronizer; the line idles high, so both stages reset to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta <= 1'b1;
      rxd_reg  <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_reg  <= rxd_meta;
    end
  end

  // Frame state machine with registered stream, busy and error outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      timer         <= '0;
      index         <= '0;
      shift         <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      busy          <= 1'b0;
      overrun_error <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      overrun_error <= 1'b0;
      frame_error   <= 1'b0;

      // A consumed byte drops tvalid; a byte landing in the same cycle
      // re-asserts it below, since the later assignment wins.
      if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!rxd_reg) begin
            state <= START;
            timer <= HALF_LOAD;
            busy  <= 1'b1;
          end
        end

        START: begin
          if (timer == '0) begin
            if (!rxd_reg) begin
              state <= DATA;
              timer <= FULL_LOAD;
              index <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            timer <= timer - TIMER_ONE;
          end
        end

        DATA: begin
          if (timer == '0) begin
            shift <= {rxd_reg, shift[DATA_WIDTH-1:1]};
            timer <= FULL_LOAD;
            if (index == LAST_INDEX) begin
              state <= STOP;
              index <= '0;
            end else begin
              index <= index + INDEX_ONE;
            end
          end else begin
            timer <= timer - TIMER_ONE;
          end
        end

        STOP: begin
          if (timer == '0) begin
            if (rxd_reg) begin
              m_axis_tdata  <= shift;
              m_axis_tvalid <= 1'b1;
              overrun_error <= m_axis_tvalid && !m_axis_tready;
            end else begin
              frame_error <= 1'b1;
            end
            state <= IDLE;
            timer <= '0;
            busy  <= 1'b0;
          end else begin
            timer <= timer - TIMER_ONE;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_caravel_uart_rx.sv
// tb_caravel_uart_rx: directed self-checking bench for caravel_uart_rx at
// 416 clocks per bit, one task per scenario with hand-computed expectations.
`timescale 1ns/1ps

module tb_caravel_uart_rx;

  localparam int CLKS = 416;

  logic       clk;
  logic       rst_n;
  logic       rxd;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic       busy;
  logic       overrun_error;
  logic       frame_error;

  int n_checks;
  int n_fail;
  int overrun_seen;
  int frame_seen;
  int valid_cycles;

  caravel_uart_rx #(
    .CLKS_PER_BIT(CLKS),
    .DATA_WIDTH  (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rxd          (rxd),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .busy         (busy),
    .overrun_error(overrun_error),
    .frame_error  (frame_error)
  );

  // 100 MHz bench clock; only the cycle count per bit matters.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count pulses and tvalid-high cycles on the falling edge, away from updates.
  initial begin
    overrun_seen = 0;
    frame_seen   = 0;
    valid_cycles = 0;
    forever begin
      @(negedge clk);
      if (overrun_error) overrun_seen = overrun_seen + 1;
      if (frame_error) frame_seen = frame_seen + 1;
      if (m_axis_tvalid) valid_cycles = valid_cycles + 1;
    end
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached (got timeout, required completion)");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic drive_bit(input logic b);
    rxd = b;
    repeat (CLKS) @(posedge clk);
    #1;
  endtask

  task automatic send_data(input logic [7:0] d);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    send_data(d);
    drive_bit(stop_bit);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    rxd = 1'b1;
    m_axis_tready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (m_axis_tdata !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL reset_tdata: got %h, required 00", m_axis_tdata);
    end
    n_checks++;
    if (m_axis_tvalid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_tvalid: got %b, required 0", m_axis_tvalid);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_busy: got %b, required 0", busy);
    end
    n_checks++;
    if (overrun_error !== 1'b0 || frame_error !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_errors: got overrun=%b frame=%b, required 0 0", overrun_error, frame_error);
    end
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    int v0;
    v0 = valid_cycles;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_frame(8'(i), 1'b1);
      n_checks++;
      if (m_axis_tdata !== 8'(i)) begin
        n_fail++;
        $display("[TB] FAIL b2b_byte%0d: got %h, required %h", i, m_axis_tdata, 8'(i));
      end
    end
    n_checks++;
    if (valid_cycles - v0 !== 8) begin
      n_fail++;
      $display("[TB] FAIL b2b_valid_cycles: got %0d, required 8", valid_cycles - v0);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL b2b_busy_idle: got %b, required 0", busy);
    end
  endtask

  task automatic test_overrun;
    int ov0;
    ov0 = overrun_seen;
    m_axis_tready = 1'b0;
    send_data(8'hA5);
    rxd = 1'b1;
    repeat (212) @(posedge clk);
    #1;
    n_checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'hA5) begin
      n_fail++;
      $display("[TB] FAIL stop_latency: got valid=%b data=%h, required 1 a5", m_axis_tvalid, m_axis_tdata);
    end
    repeat (CLKS - 212) @(posedge clk);
    #1;
    send_frame(8'h3C, 1'b1);
    n_checks++;
    if (m_axis_tdata !== 8'h3C) begin
      n_fail++;
      $display("[TB] FAIL overrun_tdata: got %h, required 3c", m_axis_tdata);
    end
    n_checks++;
    if (m_axis_tvalid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL overrun_tvalid: got %b, required 1", m_axis_tvalid);
    end
    n_checks++;
    if (overrun_seen - ov0 !== 1) begin
      n_fail++;
      $display("[TB] FAIL overrun_pulses: got %0d, required 1", overrun_seen - ov0);
    end
    m_axis_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (m_axis_tvalid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL overrun_drain: got %b, required 0", m_axis_tvalid);
    end
  endtask

  task automatic test_accept_and_new;
    int ov0;
    m_axis_tready = 1'b0;
    send_frame(8'h12, 1'b1);
    ov0 = overrun_seen;
    send_data(8'h34);
    rxd = 1'b1;
    repeat (210) @(posedge clk);
    #1;
    m_axis_tready = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'h34) begin
      n_fail++;
      $display("[TB] FAIL accept_new_load: got valid=%b data=%h, required 1 34", m_axis_tvalid, m_axis_tdata);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (m_axis_tvalid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL accept_new_clear: got %b, required 0", m_axis_tvalid);
    end
    repeat (CLKS - 212) @(posedge clk);
    #1;
    n_checks++;
    if (overrun_seen - ov0 !== 0) begin
      n_fail++;
      $display("[TB] FAIL accept_new_overrun: got %0d pulses, required 0", overrun_seen - ov0);
    end
  endtask

  task automatic test_frame_error;
    int fe0;
    int v0;
    fe0 = frame_seen;
    v0 = valid_cycles;
    m_axis_tready = 1'b1;
    send_frame(8'h55, 1'b0);
    rxd = 1'b1;
    repeat (2 * CLKS) @(posedge clk);
    #1;
    n_checks++;
    if (frame_seen - fe0 !== 1) begin
      n_fail++;
      $display("[TB] FAIL frame_err_pulses: got %0d, required 1", frame_seen - fe0);
    end
    n_checks++;
    if (valid_cycles - v0 !== 0 || m_axis_tvalid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL frame_err_tvalid: got %0d valid cycles, required 0", valid_cycles - v0);
    end
    n_checks++;
    if (m_axis_tdata !== 8'h34) begin
      n_fail++;
      $display("[TB] FAIL frame_err_tdata: got %h, required 34", m_axis_tdata);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL frame_err_busy: got %b, required 0", busy);
    end
  endtask

  task automatic test_glitch;
    int fe0;
    int ov0;
    int v0;
    fe0 = frame_seen;
    ov0 = overrun_seen;
    v0 = valid_cycles;
    rxd = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL glitch_busy_set: got %b, required 1", busy);
    end
    repeat (50) @(posedge clk);
    #1;
    rxd = 1'b1;
    repeat (CLKS) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL glitch_busy_clear: got %b, required 0", busy);
    end
    n_checks++;
    if (valid_cycles - v0 !== 0 || frame_seen - fe0 !== 0 || overrun_seen - ov0 !== 0) begin
      n_fail++;
      $display("[TB] FAIL glitch_quiet: got valid=%0d frame=%0d overrun=%0d, required 0 0 0",
               valid_cycles - v0, frame_seen - fe0, overrun_seen - ov0);
    end
  endtask

  task automatic test_reset_mid_frame;
    int v0;
    m_axis_tready = 1'b1;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    rxd = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || m_axis_tdata !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL midframe_reset: got valid=%b busy=%b data=%h, required 0 0 00",
               m_axis_tvalid, busy, m_axis_tdata);
    end
    rst_n = 1'b1;
    repeat (5 * CLKS) @(posedge clk);
    #1;
    n_checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL midframe_after_release: got valid=%b data=%h, required 0 00", m_axis_tvalid, m_axis_tdata);
    end
    v0 = valid_cycles;
    send_frame(8'h81, 1'b1);
    n_checks++;
    if (m_axis_tdata !== 8'h81 || valid_cycles - v0 !== 1) begin
      n_fail++;
      $display("[TB] FAIL midframe_next_byte: got data=%h valid_cycles=%0d, required 81 1",
               m_axis_tdata, valid_cycles - v0);
    end
  endtask

  task automatic test_single_cycle_valid;
    int v0;
    v0 = valid_cycles;
    m_axis_tready = 1'b1;
    send_frame(8'h7E, 1'b1);
    n_checks++;
    if (valid_cycles - v0 !== 1) begin
      n_fail++;
      $display("[TB] FAIL single_valid_cycles: got %0d, required 1", valid_cycles - v0);
    end
    n_checks++;
    if (m_axis_tdata !== 8'h7E || m_axis_tvalid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL single_valid_data: got data=%h valid=%b, required 7e 0", m_axis_tdata, m_axis_tvalid);
    end
  endtask

  // Scenario sequence followed by the summary line.
  initial begin
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b0;
    rxd = 1'b1;
    m_axis_tready = 1'b1;
    test_reset();
    test_back_to_back();
    test_overrun();
    test_accept_and_new();
    test_frame_error();
    test_glitch();
    test_reset_mid_frame();
    test_single_cycle_valid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
